// File: rtl/bomb_controller_if.sv
// Bus between the game logic / VGA pixel path and the bomb controller.
// The master drives frame timing, bomb requests and the current pixel;
// the slave (the bomb controller) returns its drawing request and status.
interface bomb_controller_if;
    logic        startOfFrame;
    logic        placeBomb;
    logic [5:0]  playerTileX;
    logic [5:0]  playerTileY;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        smileyDrawingRequest;
    logic        BombDrawingRequest;
    logic [7:0]  BombRGB;
    logic        bombActive;
    logic        explodePulse;
    logic        playerHit;

    modport master (
        output startOfFrame, placeBomb, playerTileX, playerTileY,
               pixelX, pixelY, smileyDrawingRequest,
        input  BombDrawingRequest, BombRGB, bombActive, explodePulse, playerHit
    );

    modport slave (
        input  startOfFrame, placeBomb, playerTileX, playerTileY,
               pixelX, pixelY, smileyDrawingRequest,
        output BombDrawingRequest, BombRGB, bombActive, explodePulse, playerHit
    );
endinterface

// File: rtl/bomb_controller.sv
// Bomb lifecycle and drawing object: latches the player tile on a place
// request, counts the fuse in frames, draws a blinking bomb and then a
// cross-shaped blast, and remembers whether the player was caught in it.
module bomb_controller #(
    parameter int TILE_SHIFT     = 5,
    parameter int FUSE_FRAMES    = 120,
    parameter int EXPLODE_FRAMES = 30,
    parameter int BLINK_FRAMES   = 8,
    parameter int RANGE          = 2
) (
    input  logic               clk,
    input  logic               reset,
    bomb_controller_if.slave   bus
);

    localparam int TILE      = 1 << TILE_SHIFT;
    localparam int FUSE_W    = $clog2(FUSE_FRAMES + 1);
    localparam int EXPLODE_W = $clog2(EXPLODE_FRAMES + 1);
    localparam int BLINK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_EXPLODING = 2'd2;

    logic [1:0]            state;
    logic [5:0]            bomb_x;
    logic [5:0]            bomb_y;
    logic [FUSE_W-1:0]     fuse;
    logic [EXPLODE_W-1:0]  explode;
    logic [BLINK_W-1:0]    blink;
    logic                  phase;

    logic [5:0]            tile_x;
    logic [5:0]            tile_y;
    logic [TILE_SHIFT-1:0] off_x;
    logic [TILE_SHIFT-1:0] off_y;
    logic [6:0]            tx7;
    logic [6:0]            ty7;
    logic [6:0]            bx7;
    logic [6:0]            by7;
    logic                  on_bomb_tile;
    logic                  bomb_hit;
    logic                  blast_hit;

    // Split the current pixel into tile index and in-tile offset, then decide
    // whether it falls on the armed bomb body or on the blast cross. Sums are
    // widened to 7 bits so arms reaching past tile 0 or 63 clip instead of wrapping.
    always_comb begin
        tile_x       = 6'(bus.pixelX >> TILE_SHIFT);
        tile_y       = 6'(bus.pixelY >> TILE_SHIFT);
        off_x        = bus.pixelX[TILE_SHIFT-1:0];
        off_y        = bus.pixelY[TILE_SHIFT-1:0];
        tx7          = {1'b0, tile_x};
        ty7          = {1'b0, tile_y};
        bx7          = {1'b0, bomb_x};
        by7          = {1'b0, bomb_y};
        on_bomb_tile = (tile_x == bomb_x) && (tile_y == bomb_y);
        bomb_hit     = (state == ST_ARMED) && on_bomb_tile &&
                       (off_x >= TILE_SHIFT'(2)) && (off_x <= TILE_SHIFT'(TILE - 3)) &&
                       (off_y >= TILE_SHIFT'(2)) && (off_y <= TILE_SHIFT'(TILE - 3));
        blast_hit    = (state == ST_EXPLODING) &&
                       (((ty7 == by7) && (tx7 + 7'(RANGE) >= bx7) && (tx7 <= bx7 + 7'(RANGE))) ||
                        ((tx7 == bx7) && (ty7 + 7'(RANGE) >= by7) && (ty7 <= by7 + 7'(RANGE))));
    end

    // The detonation strobe is high during the frame pulse that burns the last fuse frame.
    assign bus.explodePulse = !reset && (state == ST_ARMED) && bus.startOfFrame &&
                              (fuse == FUSE_W'(1));

    // Bomb lifecycle: place, count down the fuse while blinking, then hold the blast.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bomb_x         <= '0;
            bomb_y         <= '0;
            fuse           <= '0;
            explode        <= '0;
            blink          <= '0;
            phase          <= 1'b0;
            bus.bombActive <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.placeBomb) begin
                        state          <= ST_ARMED;
                        bomb_x         <= bus.playerTileX;
                        bomb_y         <= bus.playerTileY;
                        fuse           <= FUSE_W'(FUSE_FRAMES);
                        blink          <= '0;
                        phase          <= 1'b0;
                        bus.bombActive <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bus.startOfFrame) begin
                        if (fuse == FUSE_W'(1)) begin
                            state   <= ST_EXPLODING;
                            fuse    <= '0;
                            explode <= EXPLODE_W'(EXPLODE_FRAMES);
                        end else begin
                            fuse <= fuse - FUSE_W'(1);
                        end
                        if (blink == BLINK_W'(BLINK_FRAMES - 1)) begin
                            blink <= '0;
                            phase <= ~phase;
                        end else begin
                            blink <= blink + BLINK_W'(1);
                        end
                    end
                end
                ST_EXPLODING: begin
                    if (bus.startOfFrame) begin
                        if (explode == EXPLODE_W'(1)) begin
                            state          <= ST_IDLE;
                            explode        <= '0;
                            bus.bombActive <= 1'b0;
                        end else begin
                            explode <= explode - EXPLODE_W'(1);
                        end
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    bus.bombActive <= 1'b0;
                end
            endcase
        end
    end

    // Sticky player-hit flag: cleared when a new bomb is accepted, set when the player is drawn in the blast.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.playerHit <= 1'b0;
        end else if ((state == ST_IDLE) && bus.placeBomb) begin
            bus.playerHit <= 1'b0;
        end else if (blast_hit && bus.smileyDrawingRequest) begin
            bus.playerHit <= 1'b1;
        end
    end

    // Registered drawing request and colour, one cycle behind the pixel coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.BombDrawingRequest <= 1'b0;
            bus.BombRGB            <= 8'h00;
        end else begin
            bus.BombDrawingRequest <= bomb_hit || blast_hit;
            if (blast_hit) begin
                bus.BombRGB <= on_bomb_tile ? 8'hFC : 8'hF0;
            end else if (bomb_hit) begin
                bus.BombRGB <= phase ? 8'hE0 : 8'h00;
            end else begin
                bus.BombRGB <= 8'h00;
            end
        end
    end

endmodule
